// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 4,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_w_en,
    output logic [WIDTH-1:0]      fifo_data_in,
    output logic [GW-1:0]         grant_id,
    output logic                  grant_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [3:0]    LAST_BEAT = 4'(BURST - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;

    logic [GW-1:0] rr_sel;
    logic          rr_found;
    logic          in_grant;
    logic          owner_valid;
    logic          transfer;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!rr_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                rr_found = 1'b1;
                rr_sel   = GW'((int'(last_grant_q) + k) % NREQ);
            end
        end
    end

    assign in_grant     = (state_q == GRANT);
    assign owner_valid  = req_valid[grant_id_q];
    assign transfer     = in_grant & owner_valid & ~fifo_full;

    assign fifo_w_en    = transfer;
    assign grant_valid  = in_grant;
    assign grant_id     = grant_id_q;
    assign fifo_data_in = req_data[grant_id_q*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (in_grant) begin
            req_ready[grant_id_q] = ~fifo_full;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = GRANT;
                    grant_id_d = rr_sel;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (!owner_valid) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    beat_cnt_d   = '0;
                end else if (transfer) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= LAST_INIT;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int BURST = 4;
    localparam int DEPTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_w_en;
    logic [WIDTH-1:0]      fifo_data_in;
    logic [1:0]            grant_id;
    logic                  grant_valid;

    fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid)
    );

    always #5 clk = ~clk;

    logic full_force = 1'b0;
    logic fill_en    = 1'b0;
    int   fifo_level = 0;
    assign fifo_full = full_force | (fill_en && (fifo_level >= DEPTH));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rel   = 0;
    int rem  [NREQ];
    int sent [NREQ];
    logic [NREQ-1:0] vmask;
    int wr_cnt;
    int viol;
    logic [WIDTH-1:0] wr_data [$];
    int               wr_cyc  [$];

    logic            s_wen;
    logic            s_gv;
    logic [1:0]      s_gid;
    logic [NREQ-1:0] s_ready;

    function automatic logic [WIDTH-1:0] beat_word(input int i, input int b);
        return {16'(i), 16'(b)};
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rem[i] > 0) && vmask[i];
            req_data[i*WIDTH +: WIDTH] = beat_word(i, sent[i]);
        end
    endtask

    // Samples mid-cycle, then advances the requester/FIFO model just after the edge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        s_wen   = fifo_w_en;
        s_gv    = grant_valid;
        s_gid   = grant_id;
        s_ready = req_ready;
        acc     = req_valid & req_ready;
        if (fifo_w_en) begin
            wr_cnt++;
            wr_data.push_back(fifo_data_in);
            wr_cyc.push_back(cyc);
            if (fifo_full) viol++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_wen) fifo_level++;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                sent[i]++;
                rem[i]--;
            end
        end
        drive_reqs();
    endtask

    task automatic setup();
        rst_n      = 1'b0;
        full_force = 1'b0;
        fill_en    = 1'b0;
        fifo_level = 0;
        vmask      = '1;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
        end
        wr_cnt = 0;
        viol   = 0;
        wr_data.delete();
        wr_cyc.delete();
        drive_reqs();
        repeat (2) cycle();
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic test_reset();
        setup();
        for (int i = 0; i < NREQ; i++) rem[i] = 4;
        drive_reqs();
        cycle();
        tests++; if (s_gv !== 1'b0) begin fails++; $display("FAIL reset_grant_valid got %b want 0", s_gv); end
        tests++; if (s_wen !== 1'b0) begin fails++; $display("FAIL reset_w_en got %b want 0", s_wen); end
        tests++; if (s_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got %b want 0000", s_ready); end
        tests++; if (s_gid !== 2'd0) begin fails++; $display("FAIL reset_grant_id got %0d want 0", s_gid); end
    endtask

    task automatic test_alternate();
        int own;
        int bt;
        setup();
        rem[0] = 8;
        rem[2] = 8;
        drive_reqs();
        release_rst();
        for (int n = 0; n < 60 && wr_cnt < 16; n++) cycle();
        tests++; if (wr_cnt != 16) begin fails++; $display("FAIL alt_count got %0d want 16", wr_cnt); end
        for (int k = 0; k < 16 && k < wr_data.size(); k++) begin
            own = ((k / 4) % 2 == 1) ? 2 : 0;
            bt  = (k / 8) * 4 + k % 4;
            tests++;
            if (wr_data[k] !== beat_word(own, bt) || (wr_cyc[k] - rel) != 1 + k + k / 4) begin
                fails++;
                $display("FAIL alt_beat%0d got data %h at +%0d want %h at +%0d",
                         k, wr_data[k], wr_cyc[k] - rel, beat_word(own, bt), 1 + k + k / 4);
            end
        end
    endtask

    task automatic test_all_four();
        int own;
        int bt;
        setup();
        for (int i = 0; i < NREQ; i++) rem[i] = 8;
        drive_reqs();
        release_rst();
        for (int n = 0; n < 100 && wr_cnt < 20; n++) cycle();
        tests++; if (wr_cnt < 20) begin fails++; $display("FAIL four_count got %0d want >=20", wr_cnt); end
        for (int k = 0; k < 20 && k < wr_data.size(); k++) begin
            own = (k / 4) % 4;
            bt  = (k / 16) * 4 + k % 4;
            tests++;
            if (wr_data[k] !== beat_word(own, bt) || (wr_cyc[k] - rel) != 1 + k + k / 4) begin
                fails++;
                $display("FAIL four_beat%0d got data %h at +%0d want %h at +%0d",
                         k, wr_data[k], wr_cyc[k] - rel, beat_word(own, bt), 1 + k + k / 4);
            end
        end
    endtask

    task automatic test_full_stall();
        logic e_gv;
        logic e_wen;
        logic [NREQ-1:0] e_rdy;
        setup();
        rem[1] = 4;
        drive_reqs();
        release_rst();
        for (int off = 0; off <= 8; off++) begin
            full_force = (off >= 3 && off <= 5);
            e_gv  = (off >= 1 && off <= 7);
            e_wen = (off == 1 || off == 2 || off == 6 || off == 7);
            e_rdy = (e_gv && !full_force) ? 4'b0010 : 4'b0000;
            cycle();
            tests++;
            if (s_gv !== e_gv || s_wen !== e_wen || s_ready !== e_rdy) begin
                fails++;
                $display("FAIL stall_off%0d got gv=%b wen=%b rdy=%b want gv=%b wen=%b rdy=%b",
                         off, s_gv, s_wen, s_ready, e_gv, e_wen, e_rdy);
            end
        end
        full_force = 1'b0;
        tests++; if (wr_cnt != 4 || viol != 0) begin fails++; $display("FAIL stall_count got %0d writes %0d viol want 4 writes 0 viol", wr_cnt, viol); end
        for (int k = 0; k < 4 && k < wr_data.size(); k++) begin
            tests++;
            if (wr_data[k] !== beat_word(1, k)) begin
                fails++;
                $display("FAIL stall_data%0d got %h want %h", k, wr_data[k], beat_word(1, k));
            end
        end
    endtask

    task automatic test_drop();
        int e_gv  [9] = '{0, 1, 1, 1, 0, 1, 1, 0, 1};
        int e_gid [9] = '{0, 3, 3, 3, 0, 0, 0, 0, 2};
        int e_wen [9] = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
        setup();
        rem[3] = 8;
        drive_reqs();
        release_rst();
        for (int off = 0; off <= 8; off++) begin
            if (off == 3) begin
                vmask[3] = 1'b0;
                rem[0]   = 1;
                rem[2]   = 1;
                drive_reqs();
            end
            cycle();
            tests++;
            if (s_gv !== e_gv[off][0] || s_wen !== e_wen[off][0] ||
                (e_gv[off] == 1 && s_gid !== 2'(e_gid[off]))) begin
                fails++;
                $display("FAIL drop_off%0d got gv=%b gid=%0d wen=%b want gv=%0d gid=%0d wen=%0d",
                         off, s_gv, s_gid, s_wen, e_gv[off], e_gid[off], e_wen[off]);
            end
        end
    endtask

    task automatic test_reset_mid();
        setup();
        rem[2] = 8;
        drive_reqs();
        release_rst();
        repeat (3) cycle();
        tests++; if (s_wen !== 1'b1 || s_gid !== 2'd2) begin fails++; $display("FAIL rmid_pre got wen=%b gid=%0d want wen=1 gid=2", s_wen, s_gid); end
        rem[0] = 4;
        drive_reqs();
        rst_n = 1'b0;
        #1;
        tests++;
        if (grant_valid !== 1'b0 || fifo_w_en !== 1'b0 || req_ready !== 4'b0) begin
            fails++;
            $display("FAIL rmid_async got gv=%b wen=%b rdy=%b want 0 0 0000", grant_valid, fifo_w_en, req_ready);
        end
        cycle();
        tests++; if (s_gv !== 1'b0 || s_wen !== 1'b0) begin fails++; $display("FAIL rmid_cycle got gv=%b wen=%b want 0 0", s_gv, s_wen); end
        rst_n = 1'b1;
        cycle();
        tests++; if (s_gv !== 1'b0) begin fails++; $display("FAIL rmid_idle got gv=%b want 0", s_gv); end
        cycle();
        tests++;
        if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_wen !== 1'b1) begin
            fails++;
            $display("FAIL rmid_regrant got gv=%b gid=%0d wen=%b want 1 0 1", s_gv, s_gid, s_wen);
        end
        tests++;
        if (wr_data.size() != 3 || wr_data[wr_data.size()-1] !== beat_word(0, 0)) begin
            fails++;
            $display("FAIL rmid_data got %0d writes last %h want 3 writes last %h",
                     wr_data.size(), wr_data[wr_data.size()-1], beat_word(0, 0));
        end
    endtask

    task automatic test_fifo_fill();
        setup();
        for (int i = 0; i < NREQ; i++) rem[i] = 16;
        fill_en = 1'b1;
        drive_reqs();
        release_rst();
        repeat (80) cycle();
        tests++; if (wr_cnt != DEPTH) begin fails++; $display("FAIL fill_count got %0d want %0d", wr_cnt, DEPTH); end
        tests++; if (viol != 0) begin fails++; $display("FAIL fill_write_when_full got %0d want 0", viol); end
        tests++;
        if (s_wen !== 1'b0 || s_ready !== 4'b0 || s_gv !== 1'b1) begin
            fails++;
            $display("FAIL fill_stall got wen=%b rdy=%b gv=%b want 0 0000 1", s_wen, s_ready, s_gv);
        end
        fifo_level = fifo_level - 4;
        repeat (20) cycle();
        tests++; if (wr_cnt != DEPTH + 4) begin fails++; $display("FAIL fill_resume got %0d want %0d", wr_cnt, DEPTH + 4); end
        tests++; if (viol != 0) begin fails++; $display("FAIL fill_resume_viol got %0d want 0", viol); end
        fill_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_all_four();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_fifo_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001: Parameter NREQ, default 4, number of write requesters sharing one synchronous_fifo write port.
REQ-002: Parameter WIDTH, default 32, data width; equals the FIFO data width.
REQ-003: Parameter BURST, default 4, maximum beats per grant; legal range 1..16.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: req_valid  input  NREQ  bit i set: requester i presents a beat.
REQ-007: req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008: req_ready  output  NREQ  bit i set: beat of requester i accepted this cycle when req_valid[i] is also set.
REQ-009: fifo_full  input  1  FIFO full flag.
REQ-010: fifo_w_en  output  1  FIFO write enable.
REQ-011: fifo_data_in  output  WIDTH  FIFO write data.
REQ-012: grant_id  output  clog2(NREQ)  index of the current owner; valid only while grant_valid is high.
REQ-013: grant_valid  output  1  high in GRANT state.

Function
REQ-014: FSM states are exactly IDLE and GRANT; state, grant_id, last_grant and beat_cnt are registers.
REQ-015: IDLE with any req_valid bit set: select the first set bit searching round-robin from (last_grant+1) mod NREQ upward with wrap; next state GRANT, grant_id <= selected index, beat_cnt <= 0.
REQ-016: IDLE with no req_valid bit set: remain in IDLE; req_ready = 0, fifo_w_en = 0.
REQ-017: In GRANT, fifo_w_en = req_valid[grant_id] & ~fifo_full, combinationally.
REQ-018: In GRANT, req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
REQ-019: In IDLE, all req_ready bits are 0.
REQ-020: fifo_data_in = req_data slice of grant_id in every state; its value is don't-care when fifo_w_en = 0.
REQ-021: A transfer is a cycle in GRANT with fifo_w_en = 1; each transfer increments beat_cnt by 1.
REQ-022: GRANT -> IDLE on a transfer with beat_cnt = BURST-1; last_grant <= grant_id.
REQ-023: GRANT -> IDLE on a cycle where req_valid[grant_id] = 0; no transfer occurs; last_grant <= grant_id.
REQ-024: GRANT with req_valid[grant_id] = 1 and fifo_full = 1: hold state, grant_id and beat_cnt; no transfer; no timeout.
REQ-025: Latency: first beat of a request transfers no earlier than 1 cycle after req_valid rises in IDLE.
REQ-026: Every grant handover costs exactly one IDLE bubble cycle.
REQ-027: A non-owner's req_valid changes have no effect during GRANT.
REQ-028: At most one beat is written per cycle; the arbiter never asserts fifo_w_en while fifo_full = 1.

Reset
REQ-029: rst_n low asynchronously forces state = IDLE, grant_id = 0, beat_cnt = 0, last_grant = NREQ-1.
REQ-030: During reset, fifo_w_en = 0, req_ready = 0 and grant_valid = 0, regardless of clk.
REQ-031: Reset asserted mid-burst drops the burst; no fifo_w_en in the reset cycle; after release, requester 0 has highest priority.

Verification
REQ-032: Requesters 0 and 2 hold valid continuously with 8 beats each, BURST = 4, fifo never full -> grants alternate 0 (4 beats), 2 (4), 0 (4), 2 (4); one IDLE cycle between grants; FIFO read order matches.
REQ-033: All 4 requesters valid from reset release -> grant order 0, 1, 2, 3, 0; first fifo_w_en one cycle after release.
REQ-034: Requester 1 granted, fifo_full forced high for 3 cycles after beat 2 -> req_ready[1] = 0 and fifo_w_en = 0 for those 3 cycles; beats 3 and 4 follow with no loss; grant released after beat 4.
REQ-035: Requester 3 drops valid after 2 beats -> GRANT -> IDLE on the drop cycle; next grant search starts at requester 0.
REQ-036: rst_n pulsed low mid-burst of requester 2 -> fifo_w_en low within the reset cycle, grant_valid = 0; after release, requester 0 wins if valid.
REQ-037: Writing 32 beats into the 32-deep FIFO with no reads -> exactly 32 writes; fifo_w_en never high while fifo_full = 1; all requesters stall until the FIFO is read.
